// File: rtl/ula.sv
// REDUX-V arithmetic/logic unit: combinational a_in op b_in -> result_out.
// Define ULA_FLAGS_EN to register zero/carry/neg flags; otherwise the flag ports are tied to 0.
module ula #(
  parameter int ULA_OP = 4,
  parameter int BITS   = 8
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [BITS-1:0]   a_in,
  input  logic [BITS-1:0]   b_in,
  input  logic [ULA_OP-1:0] ula_op_in,
  output logic [BITS-1:0]   result_out,
  output logic              zero_out,
  output logic              carry_out,
  output logic              neg_out
);

  logic [BITS:0]   sum_ext;
  logic [BITS:0]   diff_ext;
  logic [BITS-1:0] result_c;
  logic            carry_c;

  // The borrow of the widened subtraction lands in bit BITS exactly when a_in < b_in.
  assign sum_ext  = {1'b0, a_in} + {1'b0, b_in};
  assign diff_ext = {1'b0, a_in} - {1'b0, b_in};

  always_comb begin
    result_c = '0;
    carry_c  = 1'b0;
    case (ula_op_in)
      ULA_OP'(0), ULA_OP'(1), ULA_OP'(2), ULA_OP'(3): result_c = b_in;
      ULA_OP'(4): begin
        result_c = sum_ext[BITS-1:0];
        carry_c  = sum_ext[BITS];
      end
      ULA_OP'(5): begin
        result_c = diff_ext[BITS-1:0];
        carry_c  = diff_ext[BITS];
      end
      ULA_OP'(6):  result_c = a_in & b_in;
      ULA_OP'(7):  result_c = a_in | b_in;
      ULA_OP'(8):  result_c = ~a_in;
      ULA_OP'(9):  result_c = a_in << b_in[2:0];
      ULA_OP'(10): result_c = a_in >> b_in[2:0];
      default: begin
        result_c = '0;
        carry_c  = 1'b0;
      end
    endcase
  end

  assign result_out = result_c;

`ifdef ULA_FLAGS_EN
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      zero_out  <= 1'b0;
      carry_out <= 1'b0;
      neg_out   <= 1'b0;
    end else begin
      zero_out  <= (result_c == '0);
      carry_out <= carry_c;
      neg_out   <= result_c[BITS-1];
    end
  end
`else
  // Clock and reset have no loads in this build.
  logic flags_unused;
  assign flags_unused = &{1'b0, clk_in, rst_in, carry_c};
  assign zero_out  = 1'b0;
  assign carry_out = 1'b0;
  assign neg_out   = 1'b0;
`endif

endmodule

// File: tb/tb_ula.sv
// Directed self-checking bench for ula; flag expectations follow the ULA_FLAGS_EN build option.
module tb_ula;

`ifdef ULA_FLAGS_EN
  localparam bit FLAGS_ON = 1'b1;
`else
  localparam bit FLAGS_ON = 1'b0;
`endif

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic [7:0] a_in;
  logic [7:0] b_in;
  logic [3:0] ula_op_in;
  logic [7:0] result_out;
  logic       zero_out;
  logic       carry_out;
  logic       neg_out;

  int n_checks = 0;
  int n_errors = 0;

  ula #(.ULA_OP(4), .BITS(8)) dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .a_in       (a_in),
    .b_in       (b_in),
    .ula_op_in  (ula_op_in),
    .result_out (result_out),
    .zero_out   (zero_out),
    .carry_out  (carry_out),
    .neg_out    (neg_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  task automatic apply(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    ula_op_in = op;
    a_in      = a;
    b_in      = b;
    #1;
  endtask

  task automatic edge_sample();
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    rst_in = 1'b1;
    apply(4'd0, 8'h00, 8'h00);
    edge_sample();
    chk("rst_zero",  {7'd0, zero_out},  8'h00);
    chk("rst_carry", {7'd0, carry_out}, 8'h00);
    chk("rst_neg",   {7'd0, neg_out},   8'h00);
    rst_in = 1'b0;

    // exhaustive ADD
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 256; b++) begin
        ula_op_in = 4'd4;
        a_in      = a[7:0];
        b_in      = b[7:0];
        #1;
        chk("add", result_out, 8'((a + b) % 256));
      end
    end
    apply(4'd4, 8'hFF, 8'h02);
    chk("add_ff_02", result_out, 8'h01);
    apply(4'd4, 8'hFF, 8'h01);
    chk("add_wrap", result_out, 8'h00);

    apply(4'd5, 8'h10, 8'h01);
    chk("sub_10_01", result_out, 8'h0F);
    edge_sample();
    chk("sub_nb_carry", {7'd0, carry_out}, 8'h00);
    chk("sub_nb_zero",  {7'd0, zero_out},  8'h00);
    apply(4'd5, 8'h00, 8'h01);
    chk("sub_00_01", result_out, 8'hFF);
    edge_sample();
    chk("sub_borrow", {7'd0, carry_out}, {7'd0, FLAGS_ON});
    chk("sub_neg",    {7'd0, neg_out},   {7'd0, FLAGS_ON});
    chk("sub_zero",   {7'd0, zero_out},  8'h00);

    apply(4'd6, 8'hF0, 8'h3C);
    chk("and", result_out, 8'h30);
    apply(4'd7, 8'hF0, 8'h3C);
    chk("or", result_out, 8'hFC);
    apply(4'd8, 8'hF0, 8'h3C);
    chk("not", result_out, 8'h0F);
    edge_sample();
    chk("not_carry", {7'd0, carry_out}, 8'h00);

    apply(4'd9, 8'h81, 8'h01);
    chk("slr_1", result_out, 8'h02);
    apply(4'd10, 8'h81, 8'h01);
    chk("srr_1", result_out, 8'h40);
    apply(4'd9, 8'h81, 8'h08);
    chk("slr_8", result_out, 8'h81);
    apply(4'd10, 8'h81, 8'h08);
    chk("srr_8", result_out, 8'h81);
    apply(4'd9, 8'h81, 8'h07);
    chk("slr_7", result_out, 8'h80);
    apply(4'd10, 8'h81, 8'h07);
    chk("srr_7", result_out, 8'h01);

    for (int op = 0; op < 4; op++) begin
      apply(op[3:0], 8'h12, 8'h34);
      chk("pass", result_out, 8'h34);
    end
    for (int op = 11; op < 16; op++) begin
      apply(op[3:0], 8'h12, 8'h34);
      chk("reserved", result_out, 8'h00);
    end

    // carry from an add, then reserved op clears it
    apply(4'd4, 8'h80, 8'h80);
    chk("add_80_80", result_out, 8'h00);
    edge_sample();
    chk("flag_zero",  {7'd0, zero_out},  {7'd0, FLAGS_ON});
    chk("flag_carry", {7'd0, carry_out}, {7'd0, FLAGS_ON});
    chk("flag_neg",   {7'd0, neg_out},   8'h00);
    rst_in = 1'b1;
    edge_sample();
    chk("rst2_zero",  {7'd0, zero_out},  8'h00);
    chk("rst2_carry", {7'd0, carry_out}, 8'h00);
    chk("rst2_neg",   {7'd0, neg_out},   8'h00);
    chk("rst2_result", result_out, 8'h00);
    apply(4'd6, 8'hF0, 8'h3C);
    chk("rst_and", result_out, 8'h30);
    rst_in = 1'b0;
    edge_sample();
    chk("post_rst_zero", {7'd0, zero_out}, 8'h00);
    chk("post_rst_neg",  {7'd0, neg_out},  8'h00);
    apply(4'd8, 8'h00, 8'h00);
    edge_sample();
    chk("not_neg", {7'd0, neg_out}, {7'd0, FLAGS_ON});
    apply(4'd4, 8'hFF, 8'h01);
    apply(4'd12, 8'hFF, 8'h01);
    edge_sample();
    chk("res_carry", {7'd0, carry_out}, 8'h00);
    chk("res_zero",  {7'd0, zero_out},  {7'd0, FLAGS_ON});

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
